uart_irq_ctrl: RTL and testbench

Interrupt controller stage sitting directly downstream of the UART IRQ generator. It consumes the per-event IRQ bus, applies a programmable coalescing hold-off, and presents a single level interrupt line with a latched, priority-encoded event ID. On acknowledge it returns a one-cycle one-hot clear pulse, intended to drive the generator's per-event disable inputs.

---
 rtl/uart_irq_ctrl.sv | 120 ++++++++++++
 tb/tb_uart_irq_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_irq_ctrl.sv
// Coalescing interrupt stage downstream of the UART IRQ generator: a hold-off
// delay, a level IRQ line with a latched priority ID, and a one-hot clear pulse on ack.
module uart_irq_ctrl #(
  parameter  int EVENTS_NUM = 32,
  parameter  int HOLDOFF_W  = 8,
  parameter  int CNT_W      = 16,
  localparam int ID_W       = $clog2(EVENTS_NUM)
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic [EVENTS_NUM-1:0] i_irq_bus,
  input  logic                  i_global_en,
  input  logic [HOLDOFF_W-1:0]  i_holdoff,
  input  logic                  i_ack,
  output logic                  o_irq,
  output logic [ID_W-1:0]       o_irq_id,
  output logic [EVENTS_NUM-1:0] o_clr_req,
  output logic [CNT_W-1:0]      o_served_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_HOLDOFF, S_ASSERT, S_GAP} state_e;

  state_e                state_q, state_d;
  logic [HOLDOFF_W-1:0]  cnt_q, cnt_d;
  logic                  irq_q, irq_d;
  logic [ID_W-1:0]       irq_id_q, irq_id_d;
  logic [EVENTS_NUM-1:0] clr_req_q, clr_req_d;
  logic [CNT_W-1:0]      served_cnt_q, served_cnt_d;

  logic                  any_event;
  logic [ID_W-1:0]       prio_id;

  // Lowest set index wins: scan downwards so the last hit is the lowest bit.
  function automatic logic [ID_W-1:0] prio_enc(input logic [EVENTS_NUM-1:0] bus);
    prio_enc = '0;
    for (int i = EVENTS_NUM - 1; i >= 0; i--) begin
      if (bus[i]) prio_enc = ID_W'(i);
    end
  endfunction

  assign any_event = |i_irq_bus;
  assign prio_id   = prio_enc(i_irq_bus);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and infers a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    irq_d        = irq_q;
    irq_id_d     = irq_id_q;
    clr_req_d    = '0;
    served_cnt_d = served_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_global_en && any_event) begin
          if (i_holdoff == '0) begin
            state_d  = S_ASSERT;
            irq_d    = 1'b1;
            irq_id_d = prio_id;
          end else begin
            state_d = S_HOLDOFF;
            cnt_d   = i_holdoff - HOLDOFF_W'(1);
          end
        end
      end
      S_HOLDOFF: begin
        if (!i_global_en || !any_event) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d  = S_ASSERT;
          irq_d    = 1'b1;
          irq_id_d = prio_id;
        end else begin
          cnt_d = cnt_q - HOLDOFF_W'(1);
        end
      end
      S_ASSERT: begin
        // Ack is checked first so a simultaneous withdrawal still clears and counts.
        if (i_ack) begin
          state_d   = S_GAP;
          irq_d     = 1'b0;
          clr_req_d = EVENTS_NUM'(1) << irq_id_q;
          if (served_cnt_q != '1) served_cnt_d = served_cnt_q + CNT_W'(1);
        end else if (!i_global_en || !i_irq_bus[irq_id_q]) begin
          state_d = S_GAP;
          irq_d   = 1'b0;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      irq_q        <= 1'b0;
      irq_id_q     <= '0;
      clr_req_q    <= '0;
      served_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      irq_q        <= irq_d;
      irq_id_q     <= irq_id_d;
      clr_req_q    <= clr_req_d;
      served_cnt_q <= served_cnt_d;
    end
  end

  assign o_irq        = irq_q;
  assign o_irq_id     = irq_id_q;
  assign o_clr_req    = clr_req_q;
  assign o_served_cnt = served_cnt_q;

endmodule

// File: tb/tb_uart_irq_ctrl.sv
// Bench for uart_irq_ctrl: per-feature tasks with inline checks, plus a clear-pulse
// scoreboard; a second instance with a 3-bit counter exercises saturation.
module tb_uart_irq_ctrl;

  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] bus;
  logic        en;
  logic [7:0]  holdoff;
  logic        ack;

  logic        irq;
  logic [4:0]  irq_id;
  logic [31:0] clr;
  logic [15:0] served;

  logic        s_irq;
  logic [4:0]  s_irq_id;
  logic [31:0] s_clr;
  logic [2:0]  s_served;

  int checks = 0;
  int errors = 0;
  int model_cnt = 0;

  typedef struct {
    logic [31:0] clr;
    logic [15:0] cnt;
    logic [2:0]  sat;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  uart_irq_ctrl dut (
    .i_clk(clk), .i_nrst(nrst), .i_irq_bus(bus), .i_global_en(en),
    .i_holdoff(holdoff), .i_ack(ack), .o_irq(irq), .o_irq_id(irq_id),
    .o_clr_req(clr), .o_served_cnt(served)
  );

  uart_irq_ctrl #(.CNT_W(3)) dut_sat (
    .i_clk(clk), .i_nrst(nrst), .i_irq_bus(bus), .i_global_en(en),
    .i_holdoff(holdoff), .i_ack(ack), .o_irq(s_irq), .o_irq_id(s_irq_id),
    .o_clr_req(s_clr), .o_served_cnt(s_served)
  );

  // Every clear pulse must match the oldest acknowledged event.
  always @(negedge clk) begin
    if (nrst && clr != '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_clr got=%08h exp=none", clr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (clr !== e.clr || served !== e.cnt || s_served !== e.sat) begin
          errors++;
          $display("FAIL sb_clr got clr=%08h cnt=%0d sat=%0d exp clr=%08h cnt=%0d sat=%0d",
                   clr, served, s_served, e.clr, e.cnt, e.sat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ack(input int id);
    exp_t        e;
    logic [31:0] one;
    one = 32'd1;
    model_cnt++;
    e.clr = one << id;
    e.cnt = 16'(model_cnt);
    e.sat = (model_cnt > 7) ? 3'd7 : 3'(model_cnt);
    exp_q.push_back(e);
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic e_irq, input logic [4:0] e_id,
                            input logic [31:0] e_clr);
    checks++;
    if (irq !== e_irq || irq_id !== e_id || clr !== e_clr) begin
      errors++;
      $display("FAIL %s got irq=%0b id=%0d clr=%08h exp irq=%0b id=%0d clr=%08h",
               name, irq, irq_id, clr, e_irq, e_id, e_clr);
    end
  endtask

  task automatic expect_irq_low(input string name);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL %s got irq=%0b exp irq=0", name, irq);
    end
  endtask

  task automatic expect_cnt(input string name);
    checks++;
    if (served !== 16'(model_cnt)) begin
      errors++;
      $display("FAIL %s got cnt=%0d exp cnt=%0d", name, served, model_cnt);
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0; en = 1'b0; bus = '0; holdoff = '0; ack = 1'b0;
    #2;
    expect_out("reset_outputs", 1'b0, 5'd0, 32'h0);
    expect_cnt("reset_cnt");
    tick(); tick();
    nrst = 1'b1; en = 1'b1; bus = 32'h10;
    tick();
    expect_out("pre_reset_assert", 1'b1, 5'd4, 32'h0);
    #1 nrst = 1'b0;
    #1 expect_out("async_reset_mid_assert", 1'b0, 5'd0, 32'h0);
    checks++;
    if (served !== 16'h0) begin
      errors++;
      $display("FAIL async_reset_cnt got=%0d exp=0", served);
    end
    tick();
    nrst = 1'b1;
    tick();
    expect_out("idle_after_release", 1'b1, 5'd4, 32'h0);
    do_ack(4);
    bus = '0;
    expect_out("reset_ack", 1'b0, 5'd4, 32'h10);
    tick(); tick();
  endtask

  task automatic test_priority();
    holdoff = '0; bus = 32'h0000_0014;
    tick();
    expect_out("prio_latency", 1'b1, 5'd2, 32'h0);
    do_ack(2);
    bus = 32'h10;
    expect_out("prio_ack_edge", 1'b0, 5'd2, 32'h4);
    expect_cnt("prio_cnt");
    tick();
    expect_out("prio_gap", 1'b0, 5'd2, 32'h0);
    tick();
    expect_out("prio_reassert", 1'b1, 5'd4, 32'h0);
    do_ack(4);
    bus = '0;
    tick(); tick();
  endtask

  task automatic test_holdoff();
    holdoff = 8'd5; bus = 32'h80;
    tick();
    for (int i = 1; i < 5; i++) begin
      if (i == 2) holdoff = 8'd1;
      tick();
      expect_irq_low($sformatf("holdoff_wait_%0d", i));
    end
    tick();
    expect_out("holdoff_rise", 1'b1, 5'd7, 32'h0);
    do_ack(7);
    bus = '0; holdoff = 8'd5;
    tick(); tick();
    bus = 32'h80;
    tick(); tick(); tick();
    bus = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      expect_irq_low($sformatf("holdoff_withdrawn_%0d", i));
    end
    holdoff = '0;
  endtask

  task automatic test_withdraw();
    bus = 32'h8;
    tick();
    expect_out("wd_assert", 1'b1, 5'd3, 32'h0);
    bus = '0;
    tick();
    expect_out("wd_drop", 1'b0, 5'd3, 32'h0);
    expect_cnt("wd_cnt_same");
    tick();
    expect_out("wd_gap", 1'b0, 5'd3, 32'h0);
    bus = 32'h8;
    tick();
    expect_out("wd_ack_assert", 1'b1, 5'd3, 32'h0);
    bus = '0;
    do_ack(3);
    expect_out("wd_ack_wins", 1'b0, 5'd3, 32'h8);
    expect_cnt("wd_ack_cnt");
    tick(); tick();
  endtask

  task automatic test_enable();
    en = 1'b0; bus = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_irq_low($sformatf("en_off_%0d", i));
    end
    bus = '0; en = 1'b1; ack = 1'b1;
    tick();
    ack = 1'b0;
    expect_out("stray_ack", 1'b0, 5'd3, 32'h0);
    expect_cnt("stray_ack_cnt");
  endtask

  task automatic test_stability();
    bus = 32'h20;
    tick();
    expect_out("stab_assert", 1'b1, 5'd5, 32'h0);
    bus = 32'h21;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out($sformatf("stab_hold_%0d", i), 1'b1, 5'd5, 32'h0);
    end
    do_ack(5);
    bus = 32'h01;
    expect_out("stab_clr", 1'b0, 5'd5, 32'h20);
    tick(); tick();
    expect_out("stab_next", 1'b1, 5'd0, 32'h0);
    do_ack(0);
    bus = '0;
    tick(); tick();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 6; i++) begin
      bus = 32'h2;
      tick();
      do_ack(1);
      bus = '0;
      tick(); tick();
    end
    checks++;
    if (s_served !== 3'd7) begin
      errors++;
      $display("FAIL sat_cnt got=%0d exp=7", s_served);
    end
    expect_cnt("sat_main_cnt");
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_pending got=%0d exp=0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_holdoff();
    test_withdraw();
    test_enable();
    test_stability();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
